// File: rtl/sseg_scan_ctrl.sv
// sseg_scan_ctrl: 4-digit seven-segment scan controller with tear-free frame-synchronous
// loading, per-digit enable and 16-level PWM brightness.
//
// Ports:
//   clk          in   1   system clock
//   reset_n      in   1   asynchronous active-low reset
//   wr_valid     in   1   new display contents offered
//   wr_data      in   28  {dig3,dig2,dig1,dig0}, 7b each, active-low segments
//   wr_ready     out  1   pending buffer empty; write accepted on wr_valid & wr_ready
//   digit_en     in   4   per-digit enable, 0 = digit held dark
//   bright       in   4   digit lit for (bright+1)/16 of its slot
//   blink_mask   in   4   digits that go dark during the blink phase (SSEG_BLINK_EN only)
//   an           out  4   one-hot active-high anode select, 0 = none lit
//   sseg         out  7   segment pattern of the selected digit, 7'h7F when dark
//   frame_tick   out  1   one-cycle pulse aligned with the last output of each frame
//
// Optional feature: define SSEG_BLINK_EN to add blink_mask and the blink frame counter.
`timescale 1ns/1ps
module sseg_scan_ctrl #(
    parameter int SLOT_CYCLES  = 1024,
    parameter int GUARD        = 4,
    parameter int BLINK_FRAMES = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        wr_valid,
    input  logic [27:0] wr_data,
    output logic        wr_ready,
    input  logic [3:0]  digit_en,
    input  logic [3:0]  bright,
`ifdef SSEG_BLINK_EN
    input  logic [3:0]  blink_mask,
`endif
    output logic [3:0]  an,
    output logic [6:0]  sseg,
    output logic        frame_tick
);
    localparam int            CW        = $clog2(SLOT_CYCLES);
    localparam int            PH_DIV    = SLOT_CYCLES / 16;
    localparam logic [CW-1:0] CNT_LAST  = CW'(SLOT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_GUARD = CW'(GUARD);

    if (SLOT_CYCLES < 32 || SLOT_CYCLES % 16 != 0) begin : g_bad_slot
        $error("sseg_scan_ctrl: SLOT_CYCLES must be a multiple of 16 and >= 32");
    end
    if (GUARD < 0 || GUARD >= SLOT_CYCLES) begin : g_bad_guard
        $error("sseg_scan_ctrl: GUARD out of range");
    end
    if (BLINK_FRAMES < 1) begin : g_bad_blink
        $error("sseg_scan_ctrl: BLINK_FRAMES must be >= 1");
    end

    logic [CW-1:0]   r_cnt;
    logic [1:0]      r_sel;
    logic [3:0][6:0] r_active;
    logic [27:0]     r_pend;
    logic            r_pend_full;

    logic [3:0] w_phase;
    logic       w_slot_end;
    logic       w_frame_end;
    logic       w_accept;
    logic       w_blink_dark;
    logic       w_lit;

    assign w_phase     = 4'(int'(r_cnt) / PH_DIV);
    assign w_slot_end  = (r_cnt == CNT_LAST);
    assign w_frame_end = w_slot_end & (r_sel == 2'd3);
    assign w_accept    = wr_valid & ~r_pend_full;
    assign wr_ready    = ~r_pend_full;
    // Guard blanking at slot start hides the anode/segment switch-over (ghosting).
    assign w_lit       = digit_en[r_sel] & (r_cnt >= CNT_GUARD) & (w_phase <= bright) & ~w_blink_dark;

`ifdef SSEG_BLINK_EN
    localparam int            FW        = $clog2(BLINK_FRAMES + 1);
    localparam logic [FW-1:0] FCNT_LAST = FW'(BLINK_FRAMES - 1);

    logic [FW-1:0] r_fcnt;
    logic          r_blink_ph;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fcnt     <= '0;
            r_blink_ph <= 1'b0;
        end else if (w_frame_end) begin
            r_fcnt     <= (r_fcnt == FCNT_LAST) ? '0 : r_fcnt + 1'b1;
            r_blink_ph <= (r_fcnt == FCNT_LAST) ? ~r_blink_ph : r_blink_ph;
        end
    end

    assign w_blink_dark = r_blink_ph & blink_mask[r_sel];
`else
    assign w_blink_dark = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt       <= '0;
            r_sel       <= '0;
            r_pend      <= '0;
            r_pend_full <= 1'b0;
            r_active    <= {4{7'h7F}};
            an          <= '0;
            sseg        <= 7'h7F;
            frame_tick  <= 1'b0;
        end else begin
            r_cnt      <= w_slot_end ? '0 : r_cnt + 1'b1;
            r_sel      <= w_slot_end ? r_sel + 1'b1 : r_sel;
            an         <= w_lit ? 4'b0001 << r_sel : 4'b0000;
            sseg       <= w_lit ? r_active[r_sel] : 7'h7F;
            frame_tick <= w_frame_end;
            // Commit only at frame end so a frame never mixes old and new digits;
            // pending is full here, so an accept cannot coincide with a commit.
            if (w_frame_end && r_pend_full) begin
                r_active    <= r_pend;
                r_pend_full <= 1'b0;
            end else if (w_accept) begin
                r_pend      <= wr_data;
                r_pend_full <= 1'b1;
            end
        end
    end
endmodule
